// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller
//   Central sequencer for the five-stage LC3 pipeline (Fetch, Decode, Execute,
//   MemAccess, Writeback). Generates the per-stage enables, freezes fetch
//   after a fetched BR/JMP, and holds the pipeline while data-memory
//   accesses complete. Every output is a flop computed from the next state.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous active-low reset
//   complete_instr   instruction memory returned Instr_dout this cycle
//   complete_data    data memory access finished this cycle
//   Instr_dout[15:0] instruction returned by instruction memory
//   IR_Exec[15:0]    instruction held in Execute
//   psr[2:0]         N,Z,P condition flags
//   enable_fetch     Fetch may issue an instruction read
//   enable_updatePC  Fetch loads the next PC
//   enable_decode    Decode latches
//   enable_execute   Execute latches
//   enable_writeback register-file write allowed
//   br_taken         Fetch loads the target address instead of npc
//   mem_state[1:0]   0 read, 1 indirect read, 2 write, 3 idle
//   stall            high whenever the sequencer is not in RUN
//
// State table
//   state     | meaning
//   S_RUN     | normal flow, pipeline filling or full
//   S_MEM_IND | LDI/STI pointer read in progress
//   S_MEM_RD  | data read (LD/LDR, or second half of LDI)
//   S_MEM_WR  | data write (ST/STR, or second half of STI)
//   S_BR_WAIT | fetch frozen while a BR/JMP drains to Execute

module lc3_pipe_controller #(
   parameter int BR_PENALTY  = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        complete_instr,
   input  logic        complete_data,
   input  logic [15:0] Instr_dout,
   input  logic [15:0] IR_Exec,
   input  logic [2:0]  psr,
   output logic        enable_fetch,
   output logic        enable_updatePC,
   output logic        enable_decode,
   output logic        enable_execute,
   output logic        enable_writeback,
   output logic        br_taken,
   output logic [1:0]  mem_state,
   output logic        stall
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   typedef enum logic [2:0] {
      S_RUN     = 3'd0,
      S_MEM_IND = 3'd1,
      S_MEM_RD  = 3'd2,
      S_MEM_WR  = 3'd3,
      S_BR_WAIT = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    fill_q, fill_d;
   logic [2:0]    br_cnt_q, br_cnt_d;
   logic [2:0]    br_save_q, br_save_d;
   logic          br_jmp_q, br_jmp_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          enable_fetch_q, enable_fetch_d;
   logic          enable_updatePC_q, enable_updatePC_d;
   logic          enable_decode_q, enable_decode_d;
   logic          enable_execute_q, enable_execute_d;
   logic          enable_writeback_q, enable_writeback_d;
   logic          br_taken_q, br_taken_d;
   logic [1:0]    mem_state_q, mem_state_d;
   logic          stall_q, stall_d;

   logic [3:0]    exec_op;
   logic [3:0]    fetch_op;
   logic          exec_is_mem;
   logic          fetch_is_br;
   logic          exit_ok;
   logic          exit_tmo;
   logic          exit_from_rd;
   logic          wb_force_en;
   logic          wb_force_val;
   logic          flow_d;
   logic          unused_bits;

   assign exec_op     = IR_Exec[15:12];
   assign fetch_op    = Instr_dout[15:12];
   assign unused_bits = ^{Instr_dout[11:0], IR_Exec[8:0]};

   // Memory detection is gated by the registered execute enable, so a
   // memory opcode only counts once it has really latched into Execute.
   assign exec_is_mem = enable_execute_q &&
                        (exec_op == OP_LD  || exec_op == OP_LDR ||
                         exec_op == OP_LDI || exec_op == OP_ST  ||
                         exec_op == OP_STR || exec_op == OP_STI);
   assign fetch_is_br = (fetch_op == OP_BR) || (fetch_op == OP_JMP);

   function automatic state_t mem_entry(input logic [3:0] op);
      case (op)
         OP_LD, OP_LDR:   return S_MEM_RD;
         OP_LDI, OP_STI:  return S_MEM_IND;
         default:         return S_MEM_WR;
      endcase
   endfunction

   always_comb begin
      state_d      = state_q;
      fill_d       = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
      br_cnt_d     = br_cnt_q;
      br_save_d    = br_save_q;
      br_jmp_d     = br_jmp_q;
      tmo_d        = tmo_q;
      exit_ok      = 1'b0;
      exit_tmo     = 1'b0;
      exit_from_rd = 1'b0;
      wb_force_en  = 1'b0;
      wb_force_val = 1'b0;

      case (state_q)
         S_RUN: begin
            // Memory wins over a same-cycle branch fetch; Fetch holds the
            // branch on its output so it is seen again after the access.
            if (exec_is_mem) begin
               state_d   = mem_entry(exec_op);
               tmo_d     = TW'(MEM_TIMEOUT);
               br_save_d = 3'd0;
            end else if (enable_fetch_q && complete_instr && fetch_is_br) begin
               state_d  = S_BR_WAIT;
               br_cnt_d = 3'(BR_PENALTY);
               br_jmp_d = (fetch_op == OP_JMP);
            end
         end
         S_BR_WAIT: begin
            if (exec_is_mem) begin
               state_d   = mem_entry(exec_op);
               tmo_d     = TW'(MEM_TIMEOUT);
               br_save_d = br_cnt_q - 3'd1;
            end else if (br_cnt_q == 3'd1) begin
               state_d  = S_RUN;
               br_cnt_d = 3'd0;
            end else begin
               br_cnt_d = br_cnt_q - 3'd1;
            end
         end
         S_MEM_IND: begin
            if (complete_data) begin
               if (exec_op == OP_LDI) begin
                  state_d = S_MEM_RD;
                  tmo_d   = TW'(MEM_TIMEOUT);
               end else if (exec_op == OP_STI) begin
                  state_d = S_MEM_WR;
                  tmo_d   = TW'(MEM_TIMEOUT);
               end else begin
                  exit_ok = 1'b1;
               end
            end else if (tmo_q == TW'(1)) begin
               exit_tmo = 1'b1;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         S_MEM_RD, S_MEM_WR: begin
            if (complete_data) begin
               exit_ok      = 1'b1;
               exit_from_rd = (state_q == S_MEM_RD);
            end else if (tmo_q == TW'(1)) begin
               exit_tmo = 1'b1;
            end else begin
               tmo_d = tmo_q - TW'(1);
            end
         end
         default: state_d = S_RUN;
      endcase

      // A timed-out access abandons any interrupted branch freeze; a normal
      // completion resumes it with the remaining count.
      if (exit_tmo) begin
         state_d     = S_RUN;
         br_save_d   = 3'd0;
         wb_force_en = 1'b1;
      end else if (exit_ok) begin
         state_d      = (br_save_q != 3'd0) ? S_BR_WAIT : S_RUN;
         br_cnt_d     = br_save_q;
         br_save_d    = 3'd0;
         wb_force_en  = 1'b1;
         wb_force_val = exit_from_rd;
      end

      flow_d             = (state_d == S_RUN) || (state_d == S_BR_WAIT);
      enable_fetch_d     = (state_d == S_RUN);
      enable_updatePC_d  = (state_d == S_RUN) ||
                           ((state_d == S_BR_WAIT) && (br_cnt_d == 3'd1));
      br_taken_d         = (state_d == S_BR_WAIT) && (br_cnt_d == 3'd1) &&
                           (br_jmp_d || (|(IR_Exec[11:9] & psr)));
      enable_decode_d    = flow_d && (fill_q >= 2'd1);
      enable_execute_d   = flow_d && (fill_q >= 2'd2);
      enable_writeback_d = wb_force_en ? wb_force_val
                                       : (flow_d && (fill_q == 2'd3));
      stall_d            = (state_d != S_RUN);

      case (state_d)
         S_MEM_RD:  mem_state_d = 2'd0;
         S_MEM_IND: mem_state_d = 2'd1;
         S_MEM_WR:  mem_state_d = 2'd2;
         default:   mem_state_d = 2'd3;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q            <= S_RUN;
         fill_q             <= 2'd0;
         br_cnt_q           <= 3'd0;
         br_save_q          <= 3'd0;
         br_jmp_q           <= 1'b0;
         tmo_q              <= '0;
         enable_fetch_q     <= 1'b0;
         enable_updatePC_q  <= 1'b0;
         enable_decode_q    <= 1'b0;
         enable_execute_q   <= 1'b0;
         enable_writeback_q <= 1'b0;
         br_taken_q         <= 1'b0;
         mem_state_q        <= 2'd3;
         stall_q            <= 1'b0;
      end else begin
         state_q            <= state_d;
         fill_q             <= fill_d;
         br_cnt_q           <= br_cnt_d;
         br_save_q          <= br_save_d;
         br_jmp_q           <= br_jmp_d;
         tmo_q              <= tmo_d;
         enable_fetch_q     <= enable_fetch_d;
         enable_updatePC_q  <= enable_updatePC_d;
         enable_decode_q    <= enable_decode_d;
         enable_execute_q   <= enable_execute_d;
         enable_writeback_q <= enable_writeback_d;
         br_taken_q         <= br_taken_d;
         mem_state_q        <= mem_state_d;
         stall_q            <= stall_d;
      end
   end

   assign enable_fetch     = enable_fetch_q;
   assign enable_updatePC  = enable_updatePC_q;
   assign enable_decode    = enable_decode_q;
   assign enable_execute   = enable_execute_q;
   assign enable_writeback = enable_writeback_q;
   assign br_taken         = br_taken_q;
   assign mem_state        = mem_state_q;
   assign stall            = stall_q;

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Bench for lc3_pipe_controller: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model
// (memory accesses as a queue of phases, branch freeze as a cycle count).

module tb_lc3_pipe_controller;

   localparam int BR_PENALTY  = 3;
   localparam int MEM_TIMEOUT = 15;

   logic        clock = 1'b0;
   logic        reset;
   logic        complete_instr;
   logic        complete_data;
   logic [15:0] Instr_dout;
   logic [15:0] IR_Exec;
   logic [2:0]  psr;
   logic        enable_fetch;
   logic        enable_updatePC;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_writeback;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        stall;

   always #5 clock = ~clock;

   lc3_pipe_controller #(
      .BR_PENALTY (BR_PENALTY),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .complete_instr  (complete_instr),
      .complete_data   (complete_data),
      .Instr_dout      (Instr_dout),
      .IR_Exec         (IR_Exec),
      .psr             (psr),
      .enable_fetch    (enable_fetch),
      .enable_updatePC (enable_updatePC),
      .enable_decode   (enable_decode),
      .enable_execute  (enable_execute),
      .enable_writeback(enable_writeback),
      .br_taken        (br_taken),
      .mem_state       (mem_state),
      .stall           (stall)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   // reference model: mode 0 = flowing, 1 = memory access, 2 = branch freeze
   int m_mode     = 0;
   int m_fill     = 0;
   int m_timer    = 0;
   int m_br_left  = 0;
   int m_br_saved = 0;
   bit m_br_jmp   = 0;
   int mq[$];

   bit e_fetch = 0, e_upd = 0, e_dec = 0, e_exec = 0, e_wb = 0, e_br = 0, e_stall = 0;
   int e_mem = 3;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
      end
   endtask

   function automatic bit op_is_mem(input logic [3:0] op);
      return (op == 4'h2) || (op == 4'h6) || (op == 4'hA) ||
             (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
   endfunction

   task automatic start_mem(input logic [3:0] op, input int saved);
      mq.delete();
      if (op == 4'h2 || op == 4'h6)      mq.push_back(0);
      else if (op == 4'h3 || op == 4'h7) mq.push_back(2);
      else                               mq.push_back(1);
      m_timer    = MEM_TIMEOUT;
      m_br_saved = saved;
      m_mode     = 1;
   endtask

   task automatic model_step();
      int old_fill;
      int wb_ovr;
      int head;
      bit p_exec;
      bit p_fetch;
      logic [3:0] xop;
      logic [3:0] fop;
      p_exec  = e_exec;
      p_fetch = e_fetch;
      xop     = IR_Exec[15:12];
      fop     = Instr_dout[15:12];
      if (!reset) begin
         m_mode = 0; m_fill = 0; m_timer = 0; m_br_left = 0; m_br_saved = 0;
         m_br_jmp = 0; mq.delete();
         e_fetch = 0; e_upd = 0; e_dec = 0; e_exec = 0; e_wb = 0; e_br = 0;
         e_stall = 0; e_mem = 3;
         return;
      end
      old_fill = m_fill;
      wb_ovr   = -1;
      case (m_mode)
         0: begin
            if (p_exec && op_is_mem(xop)) start_mem(xop, 0);
            else if (p_fetch && complete_instr && (fop == 4'h0 || fop == 4'hC)) begin
               m_mode    = 2;
               m_br_left = BR_PENALTY;
               m_br_jmp  = (fop == 4'hC);
            end
         end
         2: begin
            if (p_exec && op_is_mem(xop)) start_mem(xop, m_br_left - 1);
            else if (m_br_left == 1) m_mode = 0;
            else m_br_left--;
         end
         default: begin
            if (complete_data) begin
               head = mq.pop_front();
               if (head == 1) begin
                  if (xop == 4'hA)      mq.push_back(0);
                  else if (xop == 4'hB) mq.push_back(2);
               end
               if (mq.size() == 0) begin
                  wb_ovr     = (head == 0) ? 1 : 0;
                  m_mode     = (m_br_saved > 0) ? 2 : 0;
                  m_br_left  = m_br_saved;
                  m_br_saved = 0;
               end else begin
                  m_timer = MEM_TIMEOUT;
               end
            end else if (m_timer == 1) begin
               mq.delete();
               m_mode     = 0;
               m_br_saved = 0;
               wb_ovr     = 0;
            end else begin
               m_timer--;
            end
         end
      endcase
      m_fill  = (old_fill >= 3) ? 3 : old_fill + 1;
      e_fetch = (m_mode == 0);
      e_upd   = (m_mode == 0) || (m_mode == 2 && m_br_left == 1);
      e_br    = (m_mode == 2) && (m_br_left == 1) &&
                (m_br_jmp || ((IR_Exec[11:9] & psr) != 3'b000));
      e_dec   = (m_mode != 1) && (old_fill >= 1);
      e_exec  = (m_mode != 1) && (old_fill >= 2);
      if (m_mode == 1)     e_wb = 0;
      else if (wb_ovr >= 0) e_wb = (wb_ovr == 1);
      else                  e_wb = (old_fill >= 3);
      e_mem   = (m_mode == 1) ? mq[0] : 3;
      e_stall = (m_mode != 0);
   endtask

   task automatic check_all();
      chk("enable_fetch",     int'(enable_fetch),     int'(e_fetch));
      chk("enable_updatePC",  int'(enable_updatePC),  int'(e_upd));
      chk("enable_decode",    int'(enable_decode),    int'(e_dec));
      chk("enable_execute",   int'(enable_execute),   int'(e_exec));
      chk("enable_writeback", int'(enable_writeback), int'(e_wb));
      chk("br_taken",         int'(br_taken),         int'(e_br));
      chk("mem_state",        int'(mem_state),        e_mem);
      chk("stall",            int'(stall),            int'(e_stall));
   endtask

   task automatic cyc(input bit rst, input bit ci, input bit cd,
                      input logic [15:0] ins, input logic [15:0] ir,
                      input logic [2:0] p);
      reset          = rst;
      complete_instr = ci;
      complete_data  = cd;
      Instr_dout     = ins;
      IR_Exec        = ir;
      psr            = p;
      @(posedge clock);
      model_step();
      #1;
      cyc_n++;
      check_all();
   endtask

   initial begin
      logic [15:0] ins;
      logic [15:0] ir;
      logic [3:0]  op;
      bit          cd;
      bit          quiet;

      // reset for 3 cycles then pipeline fill
      repeat (3) cyc(0, 0, 0, 16'h1000, 16'h1000, 3'b000);
      repeat (6) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // LDR: complete_data on the 2nd memory cycle
      cyc(1, 0, 0, 16'h1000, 16'h6123, 3'b000);
      cyc(1, 0, 0, 16'h1000, 16'h6123, 3'b000);
      cyc(1, 0, 1, 16'h1000, 16'h6123, 3'b000);
      repeat (3) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // STI: indirect then write, each completing at once
      cyc(1, 0, 0, 16'h1000, 16'hB456, 3'b000);
      cyc(1, 0, 1, 16'h1000, 16'hB456, 3'b000);
      cyc(1, 0, 1, 16'h1000, 16'hB456, 3'b000);
      repeat (3) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // BRnzp with Z set: taken
      cyc(1, 1, 0, 16'h0E02, 16'h0E02, 3'b010);
      repeat (5) cyc(1, 0, 0, 16'h1000, 16'h0E02, 3'b010);

      // BRn with P set: not taken
      cyc(1, 1, 0, 16'h0802, 16'h0802, 3'b001);
      repeat (5) cyc(1, 0, 0, 16'h1000, 16'h0802, 3'b001);

      // reset during MEM_IND, then refill
      cyc(1, 0, 0, 16'h1000, 16'hA000, 3'b000);
      cyc(1, 0, 0, 16'h1000, 16'hA000, 3'b000);
      cyc(0, 0, 0, 16'h1000, 16'hA000, 3'b000);
      repeat (5) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // complete_data never arrives: timeout back to RUN
      cyc(1, 0, 0, 16'h1000, 16'hA000, 3'b000);
      repeat (20) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // memory opcode arriving mid branch freeze
      cyc(1, 1, 0, 16'hC000, 16'h1000, 3'b000);
      cyc(1, 0, 0, 16'h1000, 16'h2000, 3'b000);
      cyc(1, 0, 1, 16'h1000, 16'h2000, 3'b000);
      repeat (4) cyc(1, 0, 0, 16'h1000, 16'h1000, 3'b000);

      // random traffic with periodic windows where memory never answers
      for (int i = 0; i < 4000; i++) begin
         quiet = ((i / 250) % 4 == 3) && ((i % 250) < 40);
         cd    = quiet ? 1'b0 : ($urandom % 4 == 0);
         case ($urandom % 4)
            0:       ins = {4'h0, 12'($urandom)};
            1:       ins = {4'hC, 12'($urandom)};
            default: ins = 16'($urandom);
         endcase
         op = 4'($urandom);
         if (op_is_mem(op) && ($urandom % 3 != 0)) op = 4'h1;
         ir = {op, 12'($urandom)};
         cyc(($urandom % 150) != 0, ($urandom % 3) == 0, cd, ins, ir, 3'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
